// File: rtl/gf180mcu_osu_sc_12t_clkdiv_ctrl.sv
// Glitch-free programmable 50%-duty clock divider feeding the 12T clkbuf tree.
// Ratio updates and start/stop only take effect on the falling edge of Y.
module gf180mcu_osu_sc_12t_clkdiv_ctrl #(
  parameter int DIV_W = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [DIV_W-1:0] DIV,
  input  logic             DIV_VLD,
  output logic             DIV_RDY,
  output logic             DIV_DONE,
  output logic             RUN,
  output logic             Y
);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_e;

  typedef struct packed {
    logic             vld;
    logic [DIV_W-1:0] div;
  } pend_t;

  localparam logic [DIV_W-1:0] ONE = {{(DIV_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  pend_t            pend_q, pend_d;
  logic             y_q, y_d;
  logic             done_q, done_d;

  logic at_top, bnd, apply, capture;

  // bnd marks the edge where Y falls: the only safe point to retime or stop
  assign at_top  = (cnt_q == div_q);
  assign bnd     = (state_q == S_RUN) && at_top && y_q;
  assign apply   = pend_q.vld && ((state_q == S_IDLE) || bnd);
  assign capture = DIV_VLD && !pend_q.vld;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (EN)         state_d = S_RUN;
      S_RUN:  if (bnd && !EN) state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q;
    div_d  = div_q;
    pend_d = pend_q;
    y_d    = y_q;
    done_d = 1'b0;

    if (apply) begin
      div_d      = pend_q.div;
      pend_d.vld = 1'b0;
      done_d     = 1'b1;
    end
    // capture and apply are exclusive: capture needs an empty slot, apply a full one
    if (capture) begin
      pend_d.vld = 1'b1;
      pend_d.div = DIV;
    end

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        y_d   = EN;
      end
      S_RUN: begin
        if (at_top) begin
          cnt_d = '0;
          y_d   = ~y_q;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q  <= '0;
      div_q  <= '0;
      pend_q <= '0;
      y_q    <= 1'b0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      pend_q <= pend_d;
      y_q    <= y_d;
      done_q <= done_d;
    end
  end

  assign Y        = y_q;
  assign RUN      = (state_q == S_RUN);
  assign DIV_RDY  = ~pend_q.vld;
  assign DIV_DONE = done_q;

endmodule

// File: tb/tb_gf180mcu_osu_sc_12t_clkdiv_ctrl.sv
// Scoreboard bench: a phase-countdown model predicts Y/RUN/DIV_RDY/DIV_DONE each cycle,
// a monitor compares them at the falling CLK edge and probes async reset.
module tb_gf180mcu_osu_sc_12t_clkdiv_ctrl;
  localparam int DIV_W = 4;

  logic             CLK = 1'b0;
  logic             RST, EN, DIV_VLD;
  logic [DIV_W-1:0] DIV;
  logic             DIV_RDY, DIV_DONE, RUN, Y;

  gf180mcu_osu_sc_12t_clkdiv_ctrl #(.DIV_W(DIV_W)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .DIV(DIV), .DIV_VLD(DIV_VLD),
    .DIV_RDY(DIV_RDY), .DIV_DONE(DIV_DONE), .RUN(RUN), .Y(Y)
  );

  always #5 CLK = ~CLK;

  // model: current phase level and how many cycles of it remain
  bit m_run, m_y, m_pv, m_done;
  int m_left, m_ratio, m_pdiv, n_applies;
  logic [3:0] expq[$];

  int checks, errors, obs_done, cyc;
  bit tb_done, rst_seen;

  function void model_reset();
    m_run = 0; m_y = 0; m_left = 0; m_ratio = 0; m_pv = 0; m_pdiv = 0; m_done = 0;
  endfunction

  function void model_apply();
    m_ratio = m_pdiv; m_pv = 0; m_done = 1; n_applies++;
  endfunction

  function void model_step(input bit e, input bit v, input int d);
    bit cap;
    cap = v && !m_pv;
    m_done = 0;
    if (!m_run) begin
      if (m_pv) model_apply();
      if (e) begin m_run = 1; m_y = 1; m_left = m_ratio + 1; end
    end else begin
      m_left--;
      if (m_left == 0) begin
        if (m_y) begin
          if (m_pv) model_apply();
          m_y = 0;
          if (!e) m_run = 0;
          else    m_left = m_ratio + 1;
        end else begin
          m_y = 1; m_left = m_ratio + 1;
        end
      end
    end
    if (cap) begin m_pv = 1; m_pdiv = d; end
  endfunction

  task step(input bit r, input bit e, input bit v, input int d);
    RST = r; EN = e; DIV_VLD = v; DIV = d[DIV_W-1:0];
    if (r) model_reset();
    else   model_step(e, v, d);
    expq.push_back({m_y, m_run, ~m_pv, m_done});
    cyc++;
    @(negedge CLK); #1;
  endtask

  task bound_chk(input int n, input string what);
    if (n >= 200) begin
      $display("FAIL wait_%s: condition not reached within %0d cycles", what, n);
      $fatal(1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  // monitor
  initial begin
    logic [3:0] e, a;
    rst_seen = 1;
    #2;
    while (!tb_done) begin
      @(negedge CLK or posedge RST);
      if (RST && !rst_seen) begin
        rst_seen = 1;
        #1;
        a = {Y, RUN, DIV_RDY, DIV_DONE};
        checks++;
        if (a !== 4'b0010) begin
          errors++;
          $display("FAIL async_rst t=%0t Y/RUN/RDY/DONE got %b want 0010", $time, a);
        end
      end else begin
        rst_seen = RST;
        if (expq.size() > 0) begin
          e = expq.pop_front();
          a = {Y, RUN, DIV_RDY, DIV_DONE};
          if (DIV_DONE === 1'b1) obs_done++;
          checks++;
          if (a !== e) begin
            errors++;
            $display("FAIL outputs t=%0t Y/RUN/RDY/DONE got %b want %b", $time, a, e);
          end
        end
      end
    end
    checks++;
    if (obs_done != n_applies) begin
      errors++;
      $display("FAIL done_count got %0d want %0d", obs_done, n_applies);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // stimulus
  initial begin
    int n;
    bit en;
    model_reset();
    // reset with EN high and a request presented
    step(1, 1, 0, 5);
    step(1, 1, 1, 5);
    step(1, 1, 0, 5);
    // load DIV=2 while idle, then run
    step(0, 0, 1, 2);
    step(0, 0, 0, 0);
    repeat (20) step(0, 1, 0, 0);
    // ratio 3, then request 0 in the middle of a high phase
    step(0, 1, 1, 3);
    n = 0; while (m_pv && n < 200) begin step(0, 1, 0, 0); n++; end
    bound_chk(n, "apply3");
    n = 0; while (!(m_run && m_y && m_left == 2) && n < 200) begin step(0, 1, 0, 0); n++; end
    bound_chk(n, "midhigh");
    step(0, 1, 1, 0);
    repeat (16) step(0, 1, 0, 0);
    // ratio 1, drop EN in a low phase, re-raise
    step(0, 1, 1, 1);
    repeat (12) step(0, 1, 0, 0);
    n = 0; while (!(m_run && !m_y) && n < 200) begin step(0, 1, 0, 0); n++; end
    bound_chk(n, "low");
    repeat (10) step(0, 0, 0, 0);
    repeat (8) step(0, 1, 0, 0);
    // back-to-back requests 1 then 7
    n = 0; while (m_pv && n < 200) begin step(0, 1, 0, 0); n++; end
    bound_chk(n, "empty");
    step(0, 1, 1, 1);
    n = 0; while (!(m_pv && m_pdiv == 7) && n < 200) begin step(0, 1, 1, 7); n++; end
    bound_chk(n, "cap7");
    repeat (40) step(0, 1, 0, 0);
    // max ratio
    step(0, 1, 1, 15);
    repeat (80) step(0, 1, 0, 0);
    // async reset in the middle of a high phase
    n = 0; while (!(m_run && m_y && m_left <= 8) && n < 200) begin step(0, 1, 0, 0); n++; end
    bound_chk(n, "midhigh15");
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    repeat (6) step(0, 1, 0, 0);
    // randomized traffic
    en = 1;
    repeat (1500) begin
      int d;
      if ($urandom % 30 == 0) en = ~en;
      d = ($urandom % 4 == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 3));
      if ($urandom % 400 == 0) begin
        step(1, en, 0, 0);
        step(1, en, 0, 0);
      end else begin
        step(0, en, ($urandom % 6 == 0), d);
      end
    end
    repeat (4) step(0, 0, 0, 0);
    tb_done = 1;
  end
endmodule
